// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the 8-bit combinational ALU: 4-entry register file,
// IDLE/EXEC/RESP sequencing and valid/ready flow control on both channels.
// Optional feature macro: ALU_DRV_ZERO_FLAG_EN adds a registered zero flag (rsp_zero_o).
module alu_cmd_driver #(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 4,
  localparam int ADDR_W = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              reset_n,
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits for ready and payload is held while valid is high.
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_rd_i,
  input  logic [ADDR_W-1:0] cmd_rs1_i,
  input  logic [ADDR_W-1:0] cmd_rs2_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [2:0]        alu_op_o,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [ADDR_W-1:0] rsp_rd_o,
`ifdef ALU_DRV_ZERO_FLAG_EN
  output logic              rsp_zero_o,
`endif
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q;
  logic                cmd_ready_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic [2:0]          alu_op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [ADDR_W-1:0]   rsp_rd_q;
  logic [DATA_W-1:0]   rf_q [REG_CNT];
  logic [DATA_W-1:0]   rf_d [REG_CNT];
  logic                cmd_fire;
  logic                rsp_fire;
  logic                wb_en;

  assign cmd_fire = cmd_valid_i && cmd_ready_q;
  assign rsp_fire = rsp_valid_q && rsp_ready_i;
  assign wb_en    = (state_q == EXEC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            // Operands come from the pre-edge register contents; no host-write bypass.
            alu_a_q     <= rf_q[cmd_rs1_i];
            alu_b_q     <= rf_q[cmd_rs2_i];
            alu_op_q    <= cmd_op_i;
            rd_q        <= cmd_rd_i;
            cmd_ready_q <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_res_i;
          rsp_rd_q    <= rd_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_DRV_ZERO_FLAG_EN
  logic rsp_zero_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_zero_q <= 1'b0;
    end else if (wb_en) begin
      rsp_zero_q <= (alu_res_i == '0);
    end
  end

  assign rsp_zero_o = rsp_zero_q;
`endif

  // Writeback has priority over a host write to the same entry.
  always_comb begin
    rf_d = rf_q;
    for (int i = 0; i < REG_CNT; i++) begin
      if (wb_en && (rd_q == ADDR_W'(i))) begin
        rf_d[i] = alu_res_i;
      end else if (wr_en_i && (wr_addr_i == ADDR_W'(i))) begin
        rf_d[i] = wr_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_op_o    = alu_op_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_rd_o    = rsp_rd_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural ALU on alu_res_i.
module tb_alu_cmd_driver;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [2:0] cmd_op_i;
  logic [1:0] cmd_rd_i;
  logic [1:0] cmd_rs1_i;
  logic [1:0] cmd_rs2_i;
  logic       wr_en_i;
  logic [1:0] wr_addr_i;
  logic [7:0] wr_data_i;
  logic [7:0] alu_a_o;
  logic [7:0] alu_b_o;
  logic [2:0] alu_op_o;
  logic [7:0] alu_res_i;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [7:0] rsp_data_o;
  logic [1:0] rsp_rd_o;
  logic [1:0] state_o;
`ifdef ALU_DRV_ZERO_FLAG_EN
  logic       rsp_zero_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  alu_cmd_driver dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_rd_i    (cmd_rd_i),
    .cmd_rs1_i   (cmd_rs1_i),
    .cmd_rs2_i   (cmd_rs2_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_op_o    (alu_op_o),
    .alu_res_i   (alu_res_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_rd_o    (rsp_rd_o),
`ifdef ALU_DRV_ZERO_FLAG_EN
    .rsp_zero_o  (rsp_zero_o),
`endif
    .state_o     (state_o)
  );

  // Behavioural stand-in for the combinational ALU.
  always_comb begin
    alu_res_i = 8'h00;
    case (alu_op_o)
      3'b000: alu_res_i = alu_a_o + alu_b_o;
      3'b001: alu_res_i = alu_a_o - alu_b_o;
      3'b010: alu_res_i = alu_a_o & alu_b_o;
      3'b011: alu_res_i = alu_a_o | alu_b_o;
      3'b100: alu_res_i = alu_a_o ^ alu_b_o;
      3'b101: alu_res_i = alu_a_o << 1;
      3'b110: alu_res_i = alu_a_o >> 1;
      3'b111: alu_res_i = {7'd0, alu_a_o == alu_b_o};
      default: alu_res_i = 8'h00;
    endcase
  end

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid_i = 1'b0;
    cmd_op_i    = 3'd0;
    cmd_rd_i    = 2'd0;
    cmd_rs1_i   = 2'd0;
    cmd_rs2_i   = 2'd0;
    wr_en_i     = 1'b0;
    wr_addr_i   = 2'd0;
    wr_data_i   = 8'd0;
    rsp_ready_i = 1'b0;
  endtask

  task automatic host_wr(input logic [1:0] addr, input logic [7:0] data);
    wr_en_i   = 1'b1;
    wr_addr_i = addr;
    wr_data_i = data;
    step();
    wr_en_i   = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready_o !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready_o}, 32'd1);
  endtask

  task automatic check_rsp(input logic [1:0] rd, input logic exp_zero);
    logic [7:0] exp;
    check("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    check("exp_q_nonempty", exp_q.size(), (exp_q.size() == 0) ? 32'd1 : exp_q.size());
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    check("rsp_data", {24'd0, rsp_data_o}, {24'd0, exp});
    check("rsp_rd", {30'd0, rsp_rd_o}, {30'd0, rd});
    check("state_resp", {30'd0, state_o}, 32'd2);
`ifdef ALU_DRV_ZERO_FLAG_EN
    check("rsp_zero", {31'd0, rsp_zero_o}, {31'd0, exp_zero});
`else
    if (exp_zero === 1'bx) check("zero_unused", 32'd0, 32'd1);
`endif
  endtask

  // Full command: accept, EXEC operand checks, response check, response handshake.
  task automatic do_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [7:0] eres);
    wait_ready();
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_rd_i    = rd;
    cmd_rs1_i   = rs1;
    cmd_rs2_i   = rs2;
    step();
    cmd_valid_i = 1'b0;
    exp_q.push_back(eres);
    check("exec_alu_a", {24'd0, alu_a_o}, {24'd0, ea});
    check("exec_alu_b", {24'd0, alu_b_o}, {24'd0, eb});
    check("exec_alu_op", {29'd0, alu_op_o}, {29'd0, op});
    check("exec_ready", {31'd0, cmd_ready_o}, 32'd0);
    check("exec_state", {30'd0, state_o}, 32'd1);
    step();
    check_rsp(rd, eres == 8'h00);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check("post_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("post_rsp_ready", {31'd0, cmd_ready_o}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'd0, cmd_ready_o}, 32'd0);
    check({tag, "_alu"}, {13'd0, alu_op_o, alu_a_o, alu_b_o}, 32'd0);
    check({tag, "_rsp"}, {21'd0, rsp_valid_o, rsp_data_o, rsp_rd_o}, 32'd0);
    check({tag, "_state"}, {30'd0, state_o}, 32'd0);
`ifdef ALU_DRV_ZERO_FLAG_EN
    check({tag, "_zero"}, {31'd0, rsp_zero_o}, 32'd0);
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();

    // Reset with random inputs: every output stays zero.
    for (int i = 0; i < 4; i++) begin
      cmd_valid_i = 1'($urandom_range(1, 0));
      cmd_op_i    = 3'($urandom_range(7, 0));
      cmd_rd_i    = 2'($urandom_range(3, 0));
      cmd_rs1_i   = 2'($urandom_range(3, 0));
      cmd_rs2_i   = 2'($urandom_range(3, 0));
      wr_en_i     = 1'($urandom_range(1, 0));
      wr_addr_i   = 2'($urandom_range(3, 0));
      wr_data_i   = 8'($urandom_range(255, 0));
      rsp_ready_i = 1'($urandom_range(1, 0));
      step();
      check_all_zero("reset");
    end
    idle_inputs();
    reset_n = 1'b1;
    check("ready_at_release", {31'd0, cmd_ready_o}, 32'd0);
    step();
    check("ready_after_release", {31'd0, cmd_ready_o}, 32'd1);

    // Register file reads back zero after reset.
    do_cmd(3'b000, 2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 8'h00);
    do_cmd(3'b000, 2'd0, 2'd2, 2'd3, 8'h00, 8'h00, 8'h00);

    // Add, then read back the written-back result.
    host_wr(2'd0, 8'h05);
    host_wr(2'd1, 8'h03);
    do_cmd(3'b000, 2'd2, 2'd0, 2'd1, 8'h05, 8'h03, 8'h08);
    do_cmd(3'b000, 2'd3, 2'd2, 2'd0, 8'h08, 8'h05, 8'h0D);

    // Wrap-around subtraction and compare.
    host_wr(2'd0, 8'h03);
    host_wr(2'd1, 8'h05);
    do_cmd(3'b001, 2'd3, 2'd0, 2'd1, 8'h03, 8'h05, 8'hFE);
    do_cmd(3'b111, 2'd3, 2'd0, 2'd0, 8'h03, 8'h03, 8'h01);
    do_cmd(3'b001, 2'd1, 2'd0, 2'd0, 8'h03, 8'h03, 8'h00);
    // r0=03 r1=00 r2=08 r3=01
    do_cmd(3'b011, 2'd0, 2'd3, 2'd2, 8'h01, 8'h08, 8'h09);

    // Backpressure: response held, second command ignored.
    cmd_valid_i = 1'b1;
    cmd_op_i    = 3'b000;
    cmd_rd_i    = 2'd1;
    cmd_rs1_i   = 2'd0;
    cmd_rs2_i   = 2'd2;
    step();
    exp_q.push_back(8'h11);
    check("bp_alu_a", {24'd0, alu_a_o}, 32'h09);
    cmd_rs1_i = 2'd2;
    cmd_rd_i  = 2'd0;
    step();
    check_rsp(2'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("bp_data", {24'd0, rsp_data_o}, 32'h11);
      check("bp_rd", {30'd0, rsp_rd_o}, 32'd1);
      check("bp_ready", {31'd0, cmd_ready_o}, 32'd0);
      check("bp_alu_a_held", {24'd0, alu_a_o}, 32'h09);
    end
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check("bp_release_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("bp_release_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("bp_release_state", {30'd0, state_o}, 32'd0);

    // Collision: writeback beats host write on rd; other address lands.
    host_wr(2'd0, 8'h05);
    host_wr(2'd1, 8'h03);
    for (int k = 0; k < 2; k++) begin
      wait_ready();
      cmd_valid_i = 1'b1;
      cmd_op_i    = 3'b000;
      cmd_rd_i    = 2'd2;
      cmd_rs1_i   = 2'd0;
      cmd_rs2_i   = 2'd1;
      step();
      cmd_valid_i = 1'b0;
      exp_q.push_back(8'h08);
      wr_en_i   = 1'b1;
      wr_addr_i = (k == 0) ? 2'd2 : 2'd3;
      wr_data_i = (k == 0) ? 8'hAA : 8'h5C;
      step();
      wr_en_i = 1'b0;
      check_rsp(2'd2, 1'b0);
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
    end
    do_cmd(3'b100, 2'd0, 2'd2, 2'd3, 8'h08, 8'h5C, 8'h54);

    // Reset during EXEC: no writeback, no response.
    host_wr(2'd0, 8'h07);
    host_wr(2'd1, 8'h01);
    cmd_valid_i = 1'b1;
    cmd_op_i    = 3'b000;
    cmd_rd_i    = 2'd3;
    cmd_rs1_i   = 2'd0;
    cmd_rs2_i   = 2'd1;
    step();
    cmd_valid_i = 1'b0;
    check("midop_exec_state", {30'd0, state_o}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midop_reset");
    step();
    check_all_zero("midop_hold");
    reset_n = 1'b1;
    step();
    check("midop_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("midop_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    do_cmd(3'b000, 2'd0, 2'd3, 2'd0, 8'h00, 8'h00, 8'h00);
    do_cmd(3'b000, 2'd0, 2'd1, 2'd2, 8'h00, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command-side initiator for the team's 8-bit combinational ALU. It accepts register-addressed commands over a valid/ready handshake, reads two operands from a local 4-entry register file, and drives the ALU operand/opcode inputs. It then captures the ALU result, writes it back, and returns it on a valid/ready response channel. It sits between a host/sequencer and one ALU instance, and supplies everything the ALU itself lacks: storage, sequencing and flow control.

## Interface
- DATA_W, 8, operand/result width; must match the ALU (8).
- REG_CNT, 4, register-file entries; register addresses are 2 bits wide.

- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  driver can accept a command.
- cmd_op_i  input  3  ALU opcode, passed through unchanged.
- cmd_rd_i  input  2  destination register.
- cmd_rs1_i  input  2  source register for operand A.
- cmd_rs2_i  input  2  source register for operand B.
- wr_en_i  input  1  host register write.
- wr_addr_i  input  2  host write address.
- wr_data_i  input  8  host write data.
- alu_a_o  output  8  ALU operand A.
- alu_b_o  output  8  ALU operand B.
- alu_op_o  output  3  ALU opcode.
- alu_res_i  input  8  ALU combinational result.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  response consumer ready.
- rsp_data_o  output  8  result value.
- rsp_rd_o  output  2  destination register of the result.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - cmd_ready_o=1.
  - On cmd_valid_i&&cmd_ready_o, register alu_a_o=rf[rs1], alu_b_o=rf[rs2], alu_op_o=cmd_op_i, and latch rd. Go to EXEC.
  - Operands are read from the pre-edge register contents. A host write in the same cycle is not bypassed.
- **EXEC** (exactly one cycle)
  - cmd_ready_o=0. alu_*_o are held stable.
  - At the closing edge, capture alu_res_i into rsp_data_o, write rf[rd]=alu_res_i, set rsp_rd_o=rd. Go to RESP.
- **RESP**
  - rsp_valid_o=1. rsp_data_o and rsp_rd_o are held stable.
  - cmd_ready_o=0, so cmd_valid_i is ignored.
  - On rsp_ready_i: clear rsp_valid_o, go to IDLE.
- **Host write port**
  - Writes rf[wr_addr_i] on any cycle with wr_en_i=1.
  - Collision with the EXEC writeback on the same address: the writeback wins and the host write is dropped.
  - Different addresses: both writes occur.
- **Arithmetic:** the driver does no arithmetic. Results are whatever the ALU returns, modulo 2^8. Opcode 3'b111 yields 8'h00 or 8'h01.
- **Reset values** (asynchronous, while reset_n=0):
  - rf all 8'h00.
  - alu_a_o, alu_b_o, alu_op_o = 0.
  - rsp_valid_o=0, rsp_data_o=0, rsp_rd_o=0.
  - cmd_ready_o=0 while reset is asserted; 1 from the first cycle after deassertion.
- **Reset mid-operation:** any in-flight command is discarded, with no writeback and no response.

## Timing
- Accept at edge T0.
- ALU inputs are valid from T0 through T1.
- Result is captured and written back at edge T1.
- rsp_valid_o is high from T1.
- With rsp_ready_i=1, the response handshake occurs at edge T2 and cmd_ready_o is high again from T2.
- Maximum throughput is one command per 3 cycles. Each RESP cycle with rsp_ready_i=0 adds one cycle.
- The ALU path must close in one cycle: register → ALU → register.

## Configuration
- ALU_DRV_ZERO_FLAG_EN
  - Defined: adds output rsp_zero_o (1 bit), registered at edge T1 as (alu_res_i==8'h00), valid and held alongside rsp_data_o, reset value 0.
  - Undefined: the port and its flop are absent, and behaviour is otherwise identical.

## Test plan
- **Reset:** hold reset_n=0 with random inputs → every output is 0. After release, cmd_ready_o=1 and all rf reads return 8'h00.
- **Add:** host writes r0=8'h05, r1=8'h03; command op=3'b000, rd=2, rs1=0, rs2=1 → in EXEC alu_a_o=05, alu_b_o=03, alu_op_o=0; rsp_data_o=8'h08, rsp_rd_o=2; a later command with rs1=2 reads 08.
- **Wrap and compare:** r0=03, r1=05, op=3'b001 → rsp_data_o=8'hFE. Then op=3'b111 with rs1=rs2=0 → 8'h01; with ALU_DRV_ZERO_FLAG_EN defined, a result of 8'h00 sets rsp_zero_o=1.
- **Backpressure:** hold rsp_ready_i=0 for 5 cycles with cmd_valid_i=1 → rsp_valid_o, rsp_data_o and rsp_rd_o are held; cmd_ready_o=0; no second command is accepted. Raise rsp_ready_i → IDLE next cycle.
- **Collision:** host writes rf[2]=8'hAA in the EXEC cycle of a command with rd=2 and result 08 → rf[2]=08. A host write to rf[3] in the same cycle lands as written.
- **Reset mid-op:** assert reset_n=0 during EXEC → no writeback (rf stays zero), rsp_valid_o stays 0, and the driver restarts in IDLE.
